// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared constants, FSM state type and byte-lane merge for mmio_responder
package mmio_pkg;

  localparam logic [9:0]  IO_TAG_DEFAULT = 10'h1;
  localparam logic [31:0] MMIO_ID        = 32'h4D4D_494F;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // Word offsets of the timer registers relative to NUM_REGS
  localparam logic [1:0] TMR_MTIME_LO    = 2'd0;
  localparam logic [1:0] TMR_MTIME_HI    = 2'd1;
  localparam logic [1:0] TMR_MTIMECMP_LO = 2'd2;
  localparam logic [1:0] TMR_MTIMECMP_HI = 2'd3;

  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - 64-bit mtime/mtimecmp pair with registered compare interrupt
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  wr_en,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        irq
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= '0;
      mtimecmp <= '1;
      irq      <= 1'b0;
    end else begin
      irq <= (mtime >= mtimecmp);
      // A software write to either half replaces this cycle's increment
      if (wr_en[TMR_MTIME_LO] || wr_en[TMR_MTIME_HI]) begin
        if (wr_en[TMR_MTIME_LO]) mtime[31:0]  <= be_merge(mtime[31:0], wdata, be);
        if (wr_en[TMR_MTIME_HI]) mtime[63:32] <= be_merge(mtime[63:32], wdata, be);
      end else begin
        mtime <= mtime + 64'd1;
      end
      if (wr_en[TMR_MTIMECMP_LO]) mtimecmp[31:0]  <= be_merge(mtimecmp[31:0], wdata, be);
      if (wr_en[TMR_MTIMECMP_HI]) mtimecmp[63:32] <= be_merge(mtimecmp[63:32], wdata, be);
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - uncached I/O register bank responder with wait states
// Optional timer registers after the bank are built when MMIO_TIMER_EN is defined.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int         NUM_REGS    = 8,
  parameter int         WAIT_STATES = 1,
  parameter logic [9:0] IO_TAG      = IO_TAG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        timer_irq
);

  localparam int         IW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [6:0] NREG    = 7'(NUM_REGS);

  state_e      state;
  logic [3:0]  cnt;
  logic        lat_we, lat_err;
  logic [5:0]  lat_idx;
  logic [31:0] bank [NUM_REGS];

  logic [5:0]  req_idx, sel_idx;
  logic        req_in_bank, req_in_tmr, req_err, accept, bank_we;
  logic        sel_we, sel_err;
  logic [31:0] rd_word;
  logic        unused_addr;

  assign req_idx     = req_addr[7:2];
  assign req_in_bank = {1'b0, req_idx} < NREG;
  assign req_err     = (req_addr[31:22] != IO_TAG) || !(req_in_bank || req_in_tmr);
  assign accept      = req_valid && req_ready;
  assign bank_we     = accept && req_we && !req_err && req_in_bank && (req_idx != 6'd0);
  assign unused_addr = ^{req_addr[21:8], req_addr[1:0]};

  // WAIT_STATES=0 captures on the accept edge, before the latches are loaded
  assign sel_we  = (state == IDLE) ? req_we  : lat_we;
  assign sel_idx = (state == IDLE) ? req_idx : lat_idx;
  assign sel_err = (state == IDLE) ? req_err : lat_err;

`ifdef MMIO_TIMER_EN
  logic [63:0] mtime, mtimecmp;
  logic [3:0]  tmr_wr;
  logic [1:0]  req_off, sel_off;

  assign req_in_tmr = !req_in_bank && ({1'b0, req_idx} < NREG + 7'd4);
  assign req_off    = req_idx[1:0] - NREG[1:0];
  assign sel_off    = sel_idx[1:0] - NREG[1:0];
  assign tmr_wr     = (accept && req_we && !req_err && req_in_tmr) ? (4'b0001 << req_off) : 4'b0000;

  mmio_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (tmr_wr),
    .wdata    (req_wdata),
    .be       (req_be),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .irq      (timer_irq)
  );
`else
  assign req_in_tmr = 1'b0;
  assign timer_irq  = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    if (!sel_we && !sel_err) begin
      if (sel_idx == 6'd0) begin
        rd_word = MMIO_ID;
      end else if ({1'b0, sel_idx} < NREG) begin
        rd_word = bank[sel_idx[IW-1:0]];
      end
`ifdef MMIO_TIMER_EN
      else begin
        case (sel_off)
          TMR_MTIME_LO:    rd_word = mtime[31:0];
          TMR_MTIME_HI:    rd_word = mtime[63:32];
          TMR_MTIMECMP_LO: rd_word = mtimecmp[31:0];
          default:         rd_word = mtimecmp[63:32];
        endcase
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_idx    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else begin
      if (bank_we) bank[req_idx[IW-1:0]] <= be_merge(bank[req_idx[IW-1:0]], req_wdata, req_be);
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_idx   <= req_idx;
            lat_err   <= req_err;
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              resp_rdata <= rd_word;
              resp_err   <= req_err;
              state      <= RESP;
            end else begin
              cnt   <= WS_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            resp_rdata <= rd_word;
            resp_err   <= lat_err;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // resp_valid trails RESP entry by one edge: latency is WAIT_STATES+1 after accept
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - vector table plus directed sequences for mmio_responder
module tb_mmio_responder;

  localparam logic [31:0] ID = 32'h4D4D_494F;
`ifdef MMIO_TIMER_EN
  localparam logic [31:0] BAD_IDX_ADDR = 32'h0040_0030;
`else
  localparam logic [31:0] BAD_IDX_ADDR = 32'h0040_0020;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err, timer_irq;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mmio_responder #(.NUM_REGS(8), .WAIT_STATES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .timer_irq  (timer_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
    end
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    chk({tag, "_resp_err"},   32'(resp_err),   32'd0);
    chk({tag, "_timer_irq"},  32'(timer_irq),  32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    vecs[0]  = '{1'b0, 32'h0040_0000, 32'h0,         4'h0, ID,            1'b0};
    vecs[1]  = '{1'b1, 32'h0040_0004, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h0040_0004, 32'h0,         4'h0, 32'h00BB_00DD, 1'b0};
    vecs[3]  = '{1'b1, 32'h0040_0004, 32'h1122_3344, 4'hA, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0040_0004, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h0040_0004, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 32'h0040_0004, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vecs[7]  = '{1'b1, 32'h0040_0000, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 32'h0040_0000, 32'h0,         4'h0, ID,            1'b0};
    vecs[9]  = '{1'b0, BAD_IDX_ADDR,  32'h0,         4'h0, 32'h0,         1'b1};
    vecs[10] = '{1'b1, BAD_IDX_ADDR,  32'h5555_5555, 4'hF, 32'h0,         1'b1};
    vecs[11] = '{1'b0, 32'h0080_0000, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[12] = '{1'b1, 32'h0040_001C, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 32'h0040_001F, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[14] = '{1'b1, 32'h0080_001C, 32'h0,         4'hF, 32'h0,         1'b1};
    vecs[15] = '{1'b0, 32'h0040_001C, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    // Stalled response, with a competing request that must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0040_0004; req_be = 4'h0;
    @(posedge clk);
    #1 req_we = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk("stall_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_resp_valid", i), 32'(resp_valid), 32'd1);
      chk($sformatf("stall%0d_rdata", i), resp_rdata, 32'h11BB_33DD);
      chk($sformatf("stall%0d_err", i), 32'(resp_err), 32'd0);
      chk($sformatf("stall%0d_req_ready", i), 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("release_req_ready", 32'(req_ready), 32'd1);
    chk("release_resp_valid", 32'(resp_valid), 32'd0);
    do_txn(1'b0, 32'h0040_0004, 32'h0, 4'h0, rd, er, lat);
    chk("ignored_write_rdata", rd, 32'h11BB_33DD);

    // Reset asserted while in WAIT
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0040_000C;
    req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("midwait_req_ready", 32'(req_ready), 32'd0);
    chk("midwait_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midwait_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 32'h0040_0004, 32'h0, 4'h0, rd, er, lat);
    chk("cleared_idx1", rd, 32'h0);
    do_txn(1'b0, 32'h0040_000C, 32'h0, 4'h0, rd, er, lat);
    chk("cleared_idx3", rd, 32'h0);

    // Reset asserted while a response is being held
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0040_0000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("resp_held_valid", 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_outputs("resp_rst");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MMIO_TIMER_EN
    do_txn(1'b1, 32'h0040_002C, 32'h0,  4'hF, rd, er, lat);
    chk("cmp_hi_err", 32'(er), 32'd0);
    do_txn(1'b1, 32'h0040_0028, 32'd20, 4'hF, rd, er, lat);
    chk("cmp_lo_err", 32'(er), 32'd0);
    begin
      int n;
      n = 0;
      while (!timer_irq && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    chk("timer_irq_rises", 32'(timer_irq), 32'd1);
    chk("timer_irq_by_22", 32'(cyc <= 22), 32'd1);
    do_txn(1'b0, 32'h0040_0028, 32'h0, 4'h0, rd, er, lat);
    chk("cmp_lo_readback", rd, 32'd20);
`else
    repeat (30) @(negedge clk);
    chk("timer_irq_tied_off", 32'(timer_irq), 32'd0);
    do_txn(1'b0, 32'h0040_0028, 32'h0, 4'h0, rd, er, lat);
    chk("timer_window_err", 32'(er), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
